// File: rtl/led_count_gen.sv
// led_count_gen: programmable-width up/down counter with synchronous load,
// enable, prescaler, terminal-count pulse and an LED window on the count.
//
// Ports:
//   CLK       system clock (posedge only)
//   RST       synchronous reset, active-high
//   enable    count enable; gates prescaler and counter
//   load      synchronous load strobe (overrides enable)
//   value     load value
//   dir       count direction: 1 = up, 0 = down
//   prescale  counter steps every prescale+1 enabled cycles
//   led       count[LED_LSB +: LED_W], combinational from the count register
//   count     current count
//   tc        registered one-cycle terminal-count pulse
//
// Optional feature macro: LED_COUNT_SAT_EN
//   defined   -> saturating mode: the count holds at its boundary; tc pulses
//                on every step attempted at the boundary
//   undefined -> wrap-around counting
module led_count_gen #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LED_W   = 8,
    parameter int unsigned LED_LSB = 16,
    parameter int unsigned PRE_W   = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic               load,
    input  logic [WIDTH-1:0]   value,
    input  logic               dir,
    input  logic [PRE_W-1:0]   prescale,
    output logic [LED_W-1:0]   led,
    output logic [WIDTH-1:0]   count,
    output logic               tc
);

    localparam logic [WIDTH-1:0] MAX_CNT = '1;

    // Elaboration-time parameter sanity checks
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("led_count_gen: WIDTH must be >= 2");
        end
        if (LED_LSB + LED_W > WIDTH) begin : g_bad_led
            $error("led_count_gen: LED_LSB + LED_W must not exceed WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic [PRE_W-1:0] r_div;
    logic             r_tc;

    logic [WIDTH-1:0] w_count_nxt;
    logic [PRE_W-1:0] w_div_nxt;
    logic             w_tc_nxt;
    logic             w_step;
    logic             w_at_bound;

    // Next-state logic: load > enable > hold (reset handled in the register)
    always_comb begin
        w_count_nxt = r_count;
        w_div_nxt   = r_div;
        w_tc_nxt    = 1'b0;
        w_step      = 1'b0;
        w_at_bound  = dir ? (r_count == MAX_CNT) : (r_count == '0);

        if (load) begin
            w_count_nxt = value;
            w_div_nxt   = '0;
        end else if (enable) begin
            // >= rather than == so a lowered prescale cannot be overrun
            if (r_div >= prescale) begin
                w_div_nxt = '0;
                w_step    = 1'b1;
            end else begin
                w_div_nxt = r_div + PRE_W'(1);
            end

            if (w_step) begin
                w_tc_nxt = w_at_bound;
`ifdef LED_COUNT_SAT_EN
                if (!w_at_bound) begin
                    w_count_nxt = dir ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
                end
`else
                w_count_nxt = dir ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
`endif
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= '0;
            r_div   <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_div   <= w_div_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign count = r_count;
    assign led   = r_count[LED_LSB +: LED_W];
    assign tc    = r_tc;

endmodule

// File: tb/tb_led_count_gen.sv
// tb_led_count_gen: directed-vector scoreboard bench for led_count_gen.
// The driver applies one vector per cycle and queues the hand-computed
// expected count/tc; a monitor pops and compares after every posedge.
module tb_led_count_gen;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned LED_W   = 8;
    localparam int unsigned LED_LSB = 16;
    localparam int unsigned PRE_W   = 8;

    logic               CLK;
    logic               RST;
    logic               enable;
    logic               load;
    logic [WIDTH-1:0]   value;
    logic               dir;
    logic [PRE_W-1:0]   prescale;
    logic [LED_W-1:0]   led;
    logic [WIDTH-1:0]   count;
    logic               tc;

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             tc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    led_count_gen #(
        .WIDTH   (WIDTH),
        .LED_W   (LED_W),
        .LED_LSB (LED_LSB),
        .PRE_W   (PRE_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (enable),
        .load     (load),
        .value    (value),
        .dir      (dir),
        .prescale (prescale),
        .led      (led),
        .count    (count),
        .tc       (tc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Apply one vector before the next posedge and queue its expected result
    task automatic vec(input logic rst, input logic ld, input logic [WIDTH-1:0] val,
                       input logic en, input logic d, input logic [PRE_W-1:0] pre,
                       input logic [WIDTH-1:0] ecnt, input logic etc, input string nm);
        exp_t e;
        @(negedge CLK);
        RST      = rst;
        load     = ld;
        value    = val;
        enable   = en;
        dir      = d;
        prescale = pre;
        e.cnt    = ecnt;
        e.tc     = etc;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare every cycle for which an expectation is pending
    initial begin
        exp_t             e;
        string            nm;
        logic [LED_W-1:0] eled;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                eled = e.cnt[LED_LSB +: LED_W];
                checks++;
                if (count !== e.cnt) begin
                    errors++;
                    $display("FAIL %s count: got %h expected %h", nm, count, e.cnt);
                end
                checks++;
                if (led !== eled) begin
                    errors++;
                    $display("FAIL %s led: got %h expected %h", nm, led, eled);
                end
                checks++;
                if (tc !== e.tc) begin
                    errors++;
                    $display("FAIL %s tc: got %b expected %b", nm, tc, e.tc);
                end
            end
        end
    end

    initial begin
        RST = 1'b1; load = 1'b0; value = '0; enable = 1'b0; dir = 1'b1; prescale = '0;

        // 1: reset overrides load and enable
        vec(1, 1, 32'hFFFF_FFFF, 1, 1, 0, 32'h0, 0, "rst0");
        vec(1, 1, 32'hFFFF_FFFF, 1, 1, 0, 32'h0, 0, "rst1");
        vec(0, 0, 32'h0, 0, 1, 0, 32'h0, 0, "post_rst");

        // 2: load then three single-cycle steps
        vec(0, 1, 32'h00AB_0000, 1, 1, 0, 32'h00AB_0000, 0, "load_ab");
        vec(0, 0, 32'h0, 1, 1, 0, 32'h00AB_0001, 0, "up1");
        vec(0, 0, 32'h0, 1, 1, 0, 32'h00AB_0002, 0, "up2");
        vec(0, 0, 32'h0, 1, 1, 0, 32'h00AB_0003, 0, "up3");

        // 3: prescale=3 steps on every 4th enabled cycle
        vec(0, 1, 32'h0, 0, 1, 3, 32'h0, 0, "load0_pre");
        for (int i = 1; i <= 12; i++)
            vec(0, 0, 32'h0, 1, 1, 3, 32'(i / 4), 0, "pre3");

        // 4: upward terminal count
        vec(0, 1, 32'hFFFF_FFFE, 0, 1, 0, 32'hFFFF_FFFE, 0, "load_fffe");
        vec(0, 0, 32'h0, 1, 1, 0, 32'hFFFF_FFFF, 0, "up_max");
`ifdef LED_COUNT_SAT_EN
        vec(0, 0, 32'h0, 1, 1, 0, 32'hFFFF_FFFF, 1, "sat_hold_hi0");
        vec(0, 0, 32'h0, 1, 1, 0, 32'hFFFF_FFFF, 1, "sat_hold_hi1");
`else
        vec(0, 0, 32'h0, 1, 1, 0, 32'h0, 1, "wrap_up");
        vec(0, 0, 32'h0, 1, 1, 0, 32'h1, 0, "after_wrap");
`endif

        // 5: downward terminal count, then load beats a step
        vec(0, 1, 32'h0, 0, 0, 0, 32'h0, 0, "load0_dn");
`ifdef LED_COUNT_SAT_EN
        vec(0, 0, 32'h0, 1, 0, 0, 32'h0, 1, "sat_hold_lo");
`else
        vec(0, 0, 32'h0, 1, 0, 0, 32'hFFFF_FFFF, 1, "wrap_dn");
`endif
        vec(0, 1, 32'h5, 1, 0, 0, 32'h5, 0, "load_wins");
        vec(0, 0, 32'h0, 0, 0, 0, 32'h5, 0, "idle_hold");
        vec(0, 0, 32'h0, 1, 0, 0, 32'h4, 0, "down1");

        // 6: lower prescale mid-run, then pause mid-phase
        vec(0, 1, 32'h0, 0, 1, 7, 32'h0, 0, "load0_mid");
        for (int i = 0; i < 5; i++)
            vec(0, 0, 32'h0, 1, 1, 7, 32'h0, 0, "pre7_run");
        vec(0, 0, 32'h0, 1, 1, 2, 32'h1, 0, "pre_drop_step");
        vec(0, 0, 32'h0, 1, 1, 2, 32'h1, 0, "pre2_a");
        vec(0, 0, 32'h0, 1, 1, 2, 32'h1, 0, "pre2_b");
        vec(0, 0, 32'h0, 1, 1, 2, 32'h2, 0, "pre2_step");
        vec(0, 0, 32'h0, 1, 1, 2, 32'h2, 0, "pre2_div1");
        for (int i = 0; i < 4; i++)
            vec(0, 0, 32'h0, 0, 1, 2, 32'h2, 0, "pause");
        vec(0, 0, 32'h0, 1, 1, 2, 32'h2, 0, "resume_div2");
        vec(0, 0, 32'h0, 1, 1, 2, 32'h3, 0, "resume_step");

        // Reset mid-count abandons the prescale phase
        vec(0, 1, 32'h0, 0, 1, 3, 32'h0, 0, "load0_rst");
        vec(0, 0, 32'h0, 1, 1, 3, 32'h0, 0, "div1");
        vec(0, 0, 32'h0, 1, 1, 3, 32'h0, 0, "div2");
        vec(1, 0, 32'h0, 1, 1, 1, 32'h0, 0, "mid_rst");
        vec(0, 0, 32'h0, 1, 1, 1, 32'h0, 0, "rst_div1");
        vec(0, 0, 32'h0, 1, 1, 1, 32'h1, 0, "rst_step");

        @(negedge CLK);
        enable = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
